// File: rtl/serial_adder_ctrl_pkg.sv
// rtl/serial_adder_ctrl_pkg.sv - shared state encodings and default sizes for the serial adder
package serial_adder_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_CNT_W = 5;

endpackage

// File: rtl/serial_adder_ctrl_fa.sv
// rtl/serial_adder_ctrl_fa.sv - 1-bit full-adder cell used as the serial bit-slice
module serial_adder_ctrl_fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_adder_ctrl.sv
// rtl/serial_adder_ctrl.sv - bit-serial adder controller, LSB first, start/ready/done handshake
module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] psum_q, psum_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;

  logic             slice_s;
  logic             slice_co;
  logic [WIDTH-1:0] psum_shift;
  logic             accept;

  serial_adder_ctrl_fa u_slice (
    .a  (a_sh_q[0]),
    .b  (b_sh_q[0]),
    .ci (carry_q),
    .s  (slice_s),
    .co (slice_co)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    psum_d  = psum_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    accept  = 1'b0;

    // New sum bit enters at the MSB so the LSB-first result lands aligned after WIDTH shifts
    psum_shift = psum_q;
    for (int i = 0; i < WIDTH - 1; i++) begin
      psum_shift[i] = psum_q[i+1];
    end
    psum_shift[WIDTH-1] = slice_s;

    case (state_q)
      S_IDLE: begin
        if (start) accept = 1'b1;
      end
      S_RUN: begin
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        psum_d  = psum_shift;
        carry_d = slice_co;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_BIT) begin
          state_d = S_DONE;
          sum_d   = psum_shift;
          cout_d  = slice_co;
        end
      end
      S_DONE: begin
        if (start) accept = 1'b1;
        else       state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (accept) begin
      a_sh_d  = a;
      b_sh_d  = b;
      carry_d = cin;
      psum_d  = '0;
      cnt_d   = '0;
      state_d = S_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      psum_q  <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      psum_q  <= psum_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign ready = (state_q == S_IDLE) || (state_q == S_DONE);
  assign busy  = (state_q == S_RUN);
  assign done  = (state_q == S_DONE);
  assign sum   = sum_q;
  assign cout  = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb/tb_serial_adder_ctrl.sv - self-checking bench for serial_adder_ctrl against an arithmetic model
module tb_serial_adder_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         ready, busy, done, cout;
  logic [W-1:0] sum;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(W), .CNT_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    int unsigned t;
    t = int'(x) + int'(y) + int'(c);
    return t[W:0];
  endfunction

  // Drive one start pulse; returns at the negedge after the accepting edge
  task automatic start_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    @(negedge clk);
    a = x; b = y; cin = c; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts negedges after acceptance (first call at k=1) until done, bounded
  task automatic wait_done(output int cyc, output int busy_n, output bit excl_ok);
    cyc = 1; busy_n = 0; excl_ok = 1'b1;
    while (done !== 1'b1 && cyc < 40) begin
      if (busy === 1'b1) busy_n++;
      if ((ready && busy) || (done && !ready)) excl_ok = 1'b0;
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset;
    int pulses;
    logic sum_moved;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total_cnt++; if (sum !== 8'h00) $display("FAIL reset_sum got %h want 00", sum); else pass_cnt++;
    total_cnt++; if (cout !== 1'b0) $display("FAIL reset_cout got %b want 0", cout); else pass_cnt++;
    total_cnt++; if (ready !== 1'b1) $display("FAIL reset_ready got %b want 1", ready); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else pass_cnt++;
    rst_n = 1'b1;
    pulses = 0; sum_moved = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (done === 1'b1) pulses++;
      if (sum !== 8'h00 || busy !== 1'b0) sum_moved = 1'b1;
    end
    total_cnt++; if (pulses !== 0) $display("FAIL idle_no_done got %0d pulses want 0", pulses); else pass_cnt++;
    total_cnt++; if (sum_moved !== 1'b0) $display("FAIL idle_stable got change want none"); else pass_cnt++;
  endtask

  task automatic test_carry_ripple;
    int cyc, busy_n; bit ex;
    start_op(8'hFF, 8'h01, 1'b0);
    wait_done(cyc, busy_n, ex);
    total_cnt++; if (done !== 1'b1) $display("FAIL ripple_done_seen got %b want 1", done); else pass_cnt++;
    total_cnt++; if (cyc !== 9) $display("FAIL ripple_latency got %0d want 9", cyc); else pass_cnt++;
    total_cnt++; if (busy_n !== 8) $display("FAIL ripple_busy_cycles got %0d want 8", busy_n); else pass_cnt++;
    total_cnt++; if ({cout, sum} !== 9'h100) $display("FAIL ripple_result got %h want 100", {cout, sum}); else pass_cnt++;
    total_cnt++; if (ex !== 1'b1) $display("FAIL ripple_ready_busy_excl got %b want 1", ex); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (done !== 1'b0 || ready !== 1'b1 || busy !== 1'b0)
      $display("FAIL ripple_after_done got done=%b ready=%b busy=%b want 0 1 0", done, ready, busy); else pass_cnt++;
    total_cnt++; if ({cout, sum} !== 9'h100) $display("FAIL ripple_hold got %h want 100", {cout, sum}); else pass_cnt++;
  endtask

  task automatic test_carry_in;
    int cyc, busy_n; bit ex;
    start_op(8'h7F, 8'h00, 1'b1);
    wait_done(cyc, busy_n, ex);
    total_cnt++; if ({cout, sum} !== 9'h080) $display("FAIL cin_7f got %h want 080", {cout, sum}); else pass_cnt++;
    start_op(8'hFF, 8'hFF, 1'b1);
    wait_done(cyc, busy_n, ex);
    total_cnt++; if ({cout, sum} !== 9'h1FF) $display("FAIL cin_ff got %h want 1ff", {cout, sum}); else pass_cnt++;
    total_cnt++; if (cyc !== 9) $display("FAIL cin_latency got %0d want 9", cyc); else pass_cnt++;
  endtask

  task automatic test_start_ignored;
    int k, pulses;
    bit held;
    logic [W:0] prev;
    prev = {cout, sum};
    start_op(8'h12, 8'h34, 1'b0);
    k = 1; held = 1'b1;
    while (done !== 1'b1 && k < 40) begin
      if (k == 3) begin start = 1'b1; a = 8'hAA; b = 8'h55; cin = 1'b1; end
      if (k == 4) start = 1'b0;
      if ({cout, sum} !== prev) held = 1'b0;
      @(negedge clk);
      k++;
    end
    total_cnt++; if (k !== 9) $display("FAIL ignore_latency got %0d want 9", k); else pass_cnt++;
    total_cnt++; if ({cout, sum} !== 9'h046) $display("FAIL ignore_result got %h want 046", {cout, sum}); else pass_cnt++;
    total_cnt++; if (held !== 1'b1) $display("FAIL ignore_sum_held got change want held %h", prev); else pass_cnt++;
    pulses = 0;
    repeat (12) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) pulses++;
    end
    total_cnt++; if (pulses !== 0) $display("FAIL ignore_single_done got %0d extra cycles want 0", pulses); else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    int cyc, busy_n; bit ex;
    @(negedge clk);
    a = 8'h05; b = 8'h03; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    wait_done(cyc, busy_n, ex);
    total_cnt++; if ({cout, sum} !== 9'h008) $display("FAIL b2b_first got %h want 008", {cout, sum}); else pass_cnt++;
    total_cnt++; if (busy_n !== 8) $display("FAIL b2b_first_busy got %0d want 8", busy_n); else pass_cnt++;
    a = 8'h10; b = 8'h20;
    @(negedge clk);
    total_cnt++; if (busy !== 1'b1 || ready !== 1'b0)
      $display("FAIL b2b_no_idle got busy=%b ready=%b want 1 0", busy, ready); else pass_cnt++;
    start = 1'b0;
    wait_done(cyc, busy_n, ex);
    total_cnt++; if (cyc !== 9) $display("FAIL b2b_spacing got %0d want 9", cyc); else pass_cnt++;
    total_cnt++; if ({cout, sum} !== 9'h030) $display("FAIL b2b_second got %h want 030", {cout, sum}); else pass_cnt++;
  endtask

  task automatic test_reset_mid_run;
    int cyc, busy_n, pulses; bit ex;
    logic [W:0] exp;
    start_op(8'hF0, 8'h0F, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    total_cnt++; if (busy !== 1'b0 || ready !== 1'b1 || done !== 1'b0)
      $display("FAIL midrst_state got busy=%b ready=%b done=%b want 0 1 0", busy, ready, done); else pass_cnt++;
    total_cnt++; if ({cout, sum} !== 9'h000) $display("FAIL midrst_result got %h want 000", {cout, sum}); else pass_cnt++;
    rst_n = 1'b1;
    pulses = 0;
    repeat (12) begin
      @(negedge clk);
      if (done === 1'b1) pulses++;
    end
    total_cnt++; if (pulses !== 0) $display("FAIL midrst_no_done got %0d want 0", pulses); else pass_cnt++;
    exp = ref_add(8'hF0, 8'h0F, 1'b1);
    start_op(8'hF0, 8'h0F, 1'b1);
    wait_done(cyc, busy_n, ex);
    total_cnt++; if ({cout, sum} !== exp) $display("FAIL midrst_recover got %h want %h", {cout, sum}, exp); else pass_cnt++;
  endtask

  task automatic test_random;
    int cyc, busy_n; bit ex;
    logic [W-1:0] x, y;
    logic c;
    logic [W:0] exp;
    for (int n = 0; n < 24; n++) begin
      x = W'($urandom); y = W'($urandom); c = 1'($urandom);
      exp = ref_add(x, y, c);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      start_op(x, y, c);
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      wait_done(cyc, busy_n, ex);
      total_cnt++; if ({cout, sum} !== exp)
        $display("FAIL rand_result[%0d] %h+%h+%b got %h want %h", n, x, y, c, {cout, sum}, exp); else pass_cnt++;
      total_cnt++; if (cyc !== 9) $display("FAIL rand_latency[%0d] got %0d want 9", n, cyc); else pass_cnt++;
      total_cnt++; if (ex !== 1'b1) $display("FAIL rand_excl[%0d] got %b want 1", n, ex); else pass_cnt++;
    end
  endtask

  initial begin
    test_reset;
    test_carry_ripple;
    test_carry_in;
    test_start_ignored;
    test_back_to_back;
    test_reset_mid_run;
    test_random;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
